// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle a - b - bin, DIGIT bits per clock, LSB digit first
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brw,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = $clog2(NSTEP) + 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             borrow_q;
    logic [CW-1:0]    step;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dig;
    logic [WIDTH-1:0] r_next;
    logic             last;

    // One digit of full-subtractor cells; c[i] is the borrow into cell i.
    always_comb begin
        c    = '0;
        dig  = '0;
        c[0] = borrow_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i]   = a_sr[i] ^ b_sr[i] ^ c[i];
            c[i+1]   = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & c[i]);
        end
        r_next = (r_sr >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
        last   = (step == CW'(NSTEP - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            brw      <= 1'b0;
            ovf      <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            borrow_q <= 1'b0;
            step     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        r_sr     <= '0;
                        borrow_q <= bin;
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> DIGIT;
                    b_sr     <= b_sr >> DIGIT;
                    r_sr     <= r_next;
                    borrow_q <= c[DIGIT];
                    step     <= step + 1'b1;
                    // On the last digit its top cell is the word MSB.
                    if (last) begin
                        diff  <= r_next;
                        brw   <= c[DIGIT];
                        ovf   <= c[DIGIT-1] ^ c[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized checks of serial_subtractor (8/1, 8/4, 16/2)
module tb_serial_subtractor;

    logic clk;
    logic rst;

    logic       start1, bin1, busy1, done1, brw1, ovf1;
    logic [7:0] a1, b1, diff1;

    logic       start4, bin4, busy4, done4, brw4, ovf4;
    logic [7:0] a4, b4, diff4;

    logic        start16, bin16, busy16, done16, brw16, ovf16;
    logic [15:0] a16, b16, diff16;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .brw(brw1), .ovf(ovf1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .brw(brw4), .ovf(ovf4)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(2)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .brw(brw16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic run1(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] pd, input logic [7:0] ed, input logic eb,
                        input logic eo, input string tag);
        int n;
        a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, "_busy"}, 32'(busy1), 32'd1);
        tick();
        check({tag, "_hold"}, 32'(diff1), 32'(pd));
        wait_done1(n);
        check({tag, "_lat"}, 32'(n + 1), 32'd8);
        check({tag, "_diff"}, 32'(diff1), 32'(ed));
        check({tag, "_brw"}, 32'(brw1), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf1), 32'(eo));
        check({tag, "_idle"}, 32'(busy1), 32'd0);
        tick();
        check({tag, "_pulse"}, 32'(done1), 32'd0);
    endtask

    task automatic run4(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string tag);
        int n;
        a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_diff"}, 32'(diff4), 32'(ed));
        check({tag, "_brw"}, 32'(brw4), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf4), 32'(eo));
        tick();
    endtask

    initial begin
        int n, ndone, accepts, dones16;
        logic [16:0] full;
        int r;

        rst = 1'b1;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_diff", 32'(diff1), 32'd0);
        check("rst_brw", 32'(brw1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        tick();

        run1(8'h05, 8'h03, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, "v0");
        run1(8'h03, 8'h05, 1'b0, 8'h02, 8'hFE, 1'b1, 1'b0, "v1");
        run1(8'h80, 8'h01, 1'b0, 8'hFE, 8'h7F, 1'b0, 1'b1, "v2");
        run1(8'h00, 8'h00, 1'b1, 8'h7F, 8'hFF, 1'b1, 1'b0, "v3");
        run1(8'h7F, 8'hFF, 1'b0, 8'hFF, 8'h80, 1'b1, 1'b1, "v4");

        // Starts while busy are ignored; start in the done cycle is taken.
        a1 = 8'h10; b1 = 8'h04; bin1 = 1'b0; start1 = 1'b1;
        tick();
        ndone = 0;
        for (int t = 1; t <= 8; t++) begin
            if (t == 3 || t == 5) begin
                start1 = 1'b1; a1 = 8'hFF; b1 = 8'h00; bin1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            tick();
            if (done1) ndone++;
        end
        check("ign_done_cnt", 32'(ndone), 32'd1);
        check("ign_done_at8", 32'(done1), 32'd1);
        check("ign_diff", 32'(diff1), 32'h0C);
        check("ign_brw", 32'(brw1), 32'd0);
        a1 = 8'h20; b1 = 8'h01; bin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("b2b_busy", 32'(busy1), 32'd1);
        wait_done1(n);
        check("b2b_lat", 32'(n + 1), 32'd9);
        check("b2b_diff", 32'(diff1), 32'h1E);
        tick();

        // Reset in mid-operation abandons it.
        a1 = 8'h55; b1 = 8'h11; bin1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy1), 32'd0);
        check("mrst_done", 32'(done1), 32'd0);
        check("mrst_diff", 32'(diff1), 32'd0);
        check("mrst_brw", 32'(brw1), 32'd0);
        check("mrst_ovf", 32'(ovf1), 32'd0);
        ndone = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (done1) ndone++;
        end
        check("mrst_nodone", 32'(ndone), 32'd0);

        rst = 1'b1; start1 = 1'b1;
        tick();
        rst = 1'b0; start1 = 1'b0;
        check("rst_start_busy", 32'(busy1), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy1), 32'd0);

        run1(8'h55, 8'h11, 1'b0, 8'h00, 8'h44, 1'b0, 1'b0, "post_rst");

        run4(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "d4_cross");
        run4(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "d4_wrap");
        run4(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "d4_ovf");
        run4(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, "d4_bin");

        // 16/2 random back-to-back against an arithmetic reference.
        accepts = 0;
        dones16 = 0;
        for (int v = 0; v < 1000; v++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            bin16 = 1'($urandom);
            start16 = 1'b1;
            tick();
            start16 = 1'b0;
            if (busy16) accepts++;
            n = 0;
            while (!done16 && n < 30) begin
                tick();
                n++;
            end
            if (done16) dones16++;
            full = {1'b0, a16} - {1'b0, b16} - 17'(bin16);
            r = int'($signed(a16)) - int'($signed(b16)) - int'(bin16);
            check("r16_lat", 32'(n), 32'd8);
            check("r16_diff", 32'(diff16), 32'(full[15:0]));
            check("r16_brw", 32'(brw16), 32'(full[16]));
            check("r16_ovf", 32'(ovf16), 32'((r > 32767) || (r < -32768)));
        end
        check("r16_done_cnt", 32'(dones16), 32'(accepts));
        check("r16_accepts", 32'(accepts), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
